// File: rtl/pe_tile_sequencer.sv
// Layer sequencer for pe_engine: per (output channel, input tile) pair runs a filter-sync
// phase, sweeps the IFM tile row-major as data beats, then drains the PE pipe before done.
module pe_tile_sequencer #(
  parameter int W_SIZE    = 9,
  parameter int W_CHANNEL = 10,
  parameter int DRAIN_CYC = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [W_SIZE-1:0]    i_width,
  input  logic [W_SIZE-1:0]    i_height,
  input  logic [W_CHANNEL-1:0] i_q_channel,
  input  logic [W_CHANNEL-1:0] i_q_chn_out,
  input  logic                 i_ib_ready,
  input  logic                 i_pe_csync_done,
  output logic                 o_ctrl_csync_run,
  output logic                 o_ctrl_data_run,
  output logic [W_SIZE-1:0]    o_row,
  output logic [W_SIZE-1:0]    o_col,
  output logic [W_CHANNEL-1:0] o_chn,
  output logic [W_CHANNEL-1:0] o_chn_out,
  output logic                 o_is_first_row,
  output logic                 o_is_last_row,
  output logic                 o_is_first_col,
  output logic                 o_is_last_col,
  output logic                 o_is_first_chn,
  output logic                 o_is_last_chn,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int W_DRAIN = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CSYNC, S_DATA, S_NEXT, S_DRAIN, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [W_SIZE-1:0]    width_reg, height_reg;
  logic [W_SIZE-1:0]    row_reg, col_reg;
  logic [W_SIZE-1:0]    row_out_reg, col_out_reg;
  logic [W_CHANNEL-1:0] q_channel_reg, q_chn_out_reg;
  logic [W_CHANNEL-1:0] chn_reg, chn_out_reg, chn_inc;
  logic [W_DRAIN-1:0]   drain_cnt_reg;

  logic csync_run_reg, data_run_reg, busy_reg, done_reg;
  logic first_row_reg, last_row_reg, first_col_reg, last_col_reg;
  logic first_chn_reg, last_chn_reg;

  logic cfg_zero, col_at_end, row_at_end, chn_at_end, chn_out_at_end;
  logic last_shown, beat_fire, drain_end, final_pair;
  logic csync_run_next, busy_next, done_next;

  assign cfg_zero = (i_width == '0) || (i_height == '0) ||
                    (i_q_channel == '0) || (i_q_chn_out == '0);

  // row/col_reg point at the next beat to issue; *_out_reg hold the beat on the outputs.
  assign col_at_end     = (col_reg == width_reg - W_SIZE'(1));
  assign row_at_end     = (row_reg == height_reg - W_SIZE'(1));
  assign chn_at_end     = (chn_reg == q_channel_reg - W_CHANNEL'(1));
  assign chn_out_at_end = (chn_out_reg == q_chn_out_reg - W_CHANNEL'(1));
  assign chn_inc        = chn_reg + W_CHANNEL'(1);
  assign final_pair     = chn_at_end && chn_out_at_end;
  assign drain_end      = (drain_cnt_reg == W_DRAIN'(DRAIN_CYC - 1));

  // The sweep ends once the last beat is on the outputs, so that cycle issues nothing new.
  assign last_shown = data_run_reg && last_row_reg && last_col_reg;
  assign beat_fire  = (state_reg == S_DATA) && i_ib_ready && !last_shown;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (i_start) state_next = cfg_zero ? S_DONE : S_CSYNC;
      S_CSYNC: if (i_pe_csync_done) state_next = S_DATA;
      S_DATA:  if (last_shown) state_next = S_NEXT;
      S_NEXT:  state_next = final_pair ? S_DRAIN : S_CSYNC;
      S_DRAIN: if (drain_end) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    csync_run_next = (state_next == S_CSYNC);
    busy_next      = (state_next != S_IDLE);
    done_next      = (state_next == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_reg     <= '0;
      height_reg    <= '0;
      q_channel_reg <= '0;
      q_chn_out_reg <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      row_out_reg   <= '0;
      col_out_reg   <= '0;
      chn_reg       <= '0;
      chn_out_reg   <= '0;
      drain_cnt_reg <= '0;
      csync_run_reg <= 1'b0;
      data_run_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      first_row_reg <= 1'b0;
      last_row_reg  <= 1'b0;
      first_col_reg <= 1'b0;
      last_col_reg  <= 1'b0;
      first_chn_reg <= 1'b0;
      last_chn_reg  <= 1'b0;
    end else begin
      csync_run_reg <= csync_run_next;
      data_run_reg  <= beat_fire;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      case (state_reg)
        S_IDLE: begin
          if (i_start) begin
            width_reg     <= i_width;
            height_reg    <= i_height;
            q_channel_reg <= i_q_channel;
            q_chn_out_reg <= i_q_chn_out;
            row_reg       <= '0;
            col_reg       <= '0;
            row_out_reg   <= '0;
            col_out_reg   <= '0;
            chn_reg       <= '0;
            chn_out_reg   <= '0;
            drain_cnt_reg <= '0;
            first_row_reg <= 1'b1;
            last_row_reg  <= (i_height == W_SIZE'(1));
            first_col_reg <= 1'b1;
            last_col_reg  <= (i_width == W_SIZE'(1));
            first_chn_reg <= 1'b1;
            last_chn_reg  <= (i_q_channel == W_CHANNEL'(1));
          end
        end
        S_DATA: begin
          if (beat_fire) begin
            row_out_reg   <= row_reg;
            col_out_reg   <= col_reg;
            first_row_reg <= (row_reg == '0);
            last_row_reg  <= row_at_end;
            first_col_reg <= (col_reg == '0);
            last_col_reg  <= col_at_end;
            if (col_at_end) begin
              col_reg <= '0;
              row_reg <= row_at_end ? '0 : row_reg + W_SIZE'(1);
            end else begin
              col_reg <= col_reg + W_SIZE'(1);
            end
          end
        end
        S_NEXT: begin
          drain_cnt_reg <= '0;
          if (chn_at_end) begin
            chn_reg       <= '0;
            first_chn_reg <= 1'b1;
            last_chn_reg  <= (q_channel_reg == W_CHANNEL'(1));
            // Hold chn_out on the final pair so it never points past the layer.
            if (!chn_out_at_end) chn_out_reg <= chn_out_reg + W_CHANNEL'(1);
          end else begin
            chn_reg       <= chn_inc;
            first_chn_reg <= 1'b0;
            last_chn_reg  <= (chn_inc == q_channel_reg - W_CHANNEL'(1));
          end
        end
        S_DRAIN: drain_cnt_reg <= drain_cnt_reg + W_DRAIN'(1);
        default: ;
      endcase
    end
  end

  assign o_ctrl_csync_run = csync_run_reg;
  assign o_ctrl_data_run  = data_run_reg;
  assign o_row            = row_out_reg;
  assign o_col            = col_out_reg;
  assign o_chn            = chn_reg;
  assign o_chn_out        = chn_out_reg;
  assign o_is_first_row   = first_row_reg;
  assign o_is_last_row    = last_row_reg;
  assign o_is_first_col   = first_col_reg;
  assign o_is_last_col    = last_col_reg;
  assign o_is_first_chn   = first_chn_reg;
  assign o_is_last_chn    = last_chn_reg;
  assign o_busy           = busy_reg;
  assign o_done           = done_reg;

endmodule

// File: tb/tb_pe_tile_sequencer.sv
// Randomized bench for pe_tile_sequencer: a per-layer queue of expected beats in nested-loop
// order is matched against every observed beat, plus handshake, drain and reset checks.
module tb_pe_tile_sequencer;

  localparam int W_SIZE    = 9;
  localparam int W_CHANNEL = 10;
  localparam int DRAIN_CYC = 15;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 i_start = 1'b0;
  logic [W_SIZE-1:0]    i_width = '0;
  logic [W_SIZE-1:0]    i_height = '0;
  logic [W_CHANNEL-1:0] i_q_channel = '0;
  logic [W_CHANNEL-1:0] i_q_chn_out = '0;
  logic                 i_ib_ready;
  logic                 i_pe_csync_done;
  logic                 o_ctrl_csync_run, o_ctrl_data_run;
  logic [W_SIZE-1:0]    o_row, o_col;
  logic [W_CHANNEL-1:0] o_chn, o_chn_out;
  logic o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col;
  logic o_is_first_chn, o_is_last_chn, o_busy, o_done;

  always #5 clk = ~clk;

  pe_tile_sequencer #(
    .W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_width(i_width), .i_height(i_height),
    .i_q_channel(i_q_channel), .i_q_chn_out(i_q_chn_out),
    .i_ib_ready(i_ib_ready), .i_pe_csync_done(i_pe_csync_done),
    .o_ctrl_csync_run(o_ctrl_csync_run), .o_ctrl_data_run(o_ctrl_data_run),
    .o_row(o_row), .o_col(o_col), .o_chn(o_chn), .o_chn_out(o_chn_out),
    .o_is_first_row(o_is_first_row), .o_is_last_row(o_is_last_row),
    .o_is_first_col(o_is_first_col), .o_is_last_col(o_is_last_col),
    .o_is_first_chn(o_is_first_chn), .o_is_last_chn(o_is_last_chn),
    .o_busy(o_busy), .o_done(o_done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // expected beat = {chn_out, chn, row, col, first_row, last_row, first_col, last_col, first_chn, last_chn}
  logic [43:0] exp_q[$];
  int  beat_cnt, csync_cnt, done_cnt, cyc, last_beat_cyc, done_cyc, csync_len;
  bit  done_seen, ignore_beats, hold_done_mode;
  int  ready_mode, csync_delay;
  logic        prev_csync, prev_data, prev_busy;
  logic [17:0] prev_coord;

  initial begin
    beat_cnt = 0; csync_cnt = 0; done_cnt = 0; cyc = 0; last_beat_cyc = 0;
    done_cyc = 0; csync_len = 0; done_seen = 0; ignore_beats = 0;
    hold_done_mode = 0; ready_mode = 0; csync_delay = 2;
  end

  function automatic logic [63:0] all_outputs();
    return 64'({o_ctrl_csync_run, o_ctrl_data_run, o_row, o_col, o_chn, o_chn_out,
                o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col,
                o_is_first_chn, o_is_last_chn, o_busy, o_done});
  endfunction

  // IFM buffer readiness and pe_engine filter-load responder
  initial begin
    int cnt;
    cnt = 0;
    i_ib_ready = 1'b0;
    i_pe_csync_done = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       i_ib_ready = 1'b1;
        1:       i_ib_ready = ~i_ib_ready;
        default: i_ib_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (hold_done_mode) begin
        i_pe_csync_done = 1'b1;
      end else if (o_ctrl_csync_run) begin
        cnt++;
        i_pe_csync_done = (cnt >= csync_delay);
      end else begin
        cnt = 0;
        i_pe_csync_done = 1'b0;
      end
    end
  end

  // Output monitor
  initial begin
    logic [43:0] e;
    prev_csync = 0; prev_data = 0; prev_busy = 0; prev_coord = '0;
    forever begin
      @(negedge clk);
      cyc++;
      check_eq("run_overlap", 64'(o_ctrl_csync_run & o_ctrl_data_run), 64'(0));
      check_eq("run_gap", 64'((o_ctrl_data_run & prev_csync) | (o_ctrl_csync_run & prev_data)), 64'(0));
      if (o_ctrl_data_run && !ignore_beats) begin
        beat_cnt++;
        last_beat_cyc = cyc;
        check_eq("beat_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("beat_coord", 64'({o_chn_out, o_chn, o_row, o_col}), 64'(e[43:6]));
          check_eq("beat_flags", 64'({o_is_first_row, o_is_last_row, o_is_first_col,
                                      o_is_last_col, o_is_first_chn, o_is_last_chn}), 64'(e[5:0]));
        end
      end
      if (!o_ctrl_data_run && prev_busy && o_busy)
        check_eq("coord_hold", 64'({o_row, o_col}), 64'(prev_coord));
      if (o_ctrl_csync_run) begin
        if (!prev_csync) csync_cnt++;
        csync_len++;
      end else if (prev_csync) begin
        if (hold_done_mode) check_eq("csync_len", 64'(csync_len), 64'(1));
        csync_len = 0;
      end
      if (o_done) begin
        done_cnt++;
        done_seen = 1;
        done_cyc = cyc;
        check_eq("busy_at_done", 64'(o_busy), 64'(1));
      end
      prev_csync = o_ctrl_csync_run;
      prev_data  = o_ctrl_data_run;
      prev_busy  = o_busy;
      prev_coord = {o_row, o_col};
    end
  end

  task automatic build_expected(input int w, input int h, input int qc, input int qco);
    exp_q.delete();
    for (int co = 0; co < qco; co++)
      for (int c = 0; c < qc; c++)
        for (int r = 0; r < h; r++)
          for (int cl = 0; cl < w; cl++)
            exp_q.push_back({10'(co), 10'(c), 9'(r), 9'(cl),
                             r == 0, r == h - 1, cl == 0, cl == w - 1, c == 0, c == qc - 1});
  endtask

  task automatic pulse_start(input int w, input int h, input int qc, input int qco);
    @(negedge clk);
    i_width = W_SIZE'(w); i_height = W_SIZE'(h);
    i_q_channel = W_CHANNEL'(qc); i_q_chn_out = W_CHANNEL'(qco);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic recover();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_layer(input int w, input int h, input int qc, input int qco,
                           input int rm, input int dly, input bit hold, input bit mid_start);
    int k, budget;
    ready_mode = rm; csync_delay = dly; hold_done_mode = hold;
    build_expected(w, h, qc, qco);
    beat_cnt = 0; csync_cnt = 0; done_cnt = 0; done_seen = 0;
    pulse_start(w, h, qc, qco);
    if (mid_start) begin
      k = 0;
      while (beat_cnt < 2 && k < 500) begin @(posedge clk); k++; end
      check_eq("mid_start_reach", 64'(beat_cnt >= 2), 64'(1));
      pulse_start(7, 5, 3, 2);
    end
    budget = (w * h * 4 + 40) * qc * qco + 100;
    k = 0;
    while (!done_seen && k < budget) begin @(posedge clk); k++; end
    check_eq("done_seen", 64'(done_seen), 64'(1));
    check_eq("beat_count", 64'(beat_cnt), 64'(w * h * qc * qco));
    check_eq("beats_left", 64'(exp_q.size()), 64'(0));
    check_eq("csync_phases", 64'(csync_cnt), 64'(qc * qco));
    check_eq("drain_gap", 64'((done_cyc - last_beat_cyc) >= DRAIN_CYC), 64'(1));
    @(negedge clk);
    check_eq("idle_after_done", 64'(o_busy), 64'(0));
    check_eq("done_pulses", 64'(done_cnt), 64'(1));
    $display("layer %0dx%0d qc=%0d qco=%0d ready_mode=%0d beats=%0d csync=%0d",
             w, h, qc, qco, rm, beat_cnt, csync_cnt);
    if (!done_seen) recover();
  endtask

  task automatic run_zero_cfg(input int w, input int h, input int qc, input int qco);
    int k;
    exp_q.delete();
    beat_cnt = 0; csync_cnt = 0; done_cnt = 0; done_seen = 0;
    pulse_start(w, h, qc, qco);
    k = 0;
    while (!done_seen && k < 20) begin @(posedge clk); k++; end
    check_eq("zero_done_seen", 64'(done_seen), 64'(1));
    check_eq("zero_done_latency", 64'(k <= 2), 64'(1));
    check_eq("zero_no_csync", 64'(csync_cnt), 64'(0));
    check_eq("zero_no_beats", 64'(beat_cnt), 64'(0));
    @(negedge clk);
    check_eq("zero_idle", 64'(o_busy), 64'(0));
    $display("layer zero-cfg %0dx%0d qc=%0d qco=%0d done after %0d cycles", w, h, qc, qco, k);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", all_outputs(), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_outputs", all_outputs(), 64'(0));

    // Abort mid-DATA
    ready_mode = 0; csync_delay = 2; hold_done_mode = 0;
    build_expected(4, 4, 2, 1);
    beat_cnt = 0; done_cnt = 0;
    pulse_start(4, 4, 2, 1);
    k = 0;
    while (beat_cnt < 5 && k < 200) begin @(posedge clk); k++; end
    check_eq("abort_reach_data", 64'(beat_cnt >= 5), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    ignore_beats = 1;
    @(negedge clk);
    check_eq("abort_outputs", all_outputs(), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("abort_no_done", 64'(done_cnt), 64'(0));
    check_eq("abort_idle", 64'(o_busy), 64'(0));
    exp_q.delete();
    ignore_beats = 0;
    $display("layer 4x4 qc=2 qco=1 aborted by reset after %0d beats", beat_cnt);

    run_layer(3, 2, 2, 1, 0, 2, 0, 0);
    run_layer(4, 4, 1, 1, 1, 2, 0, 0);
    run_layer(1, 1, 1, 3, 0, 2, 0, 0);
    run_layer(3, 3, 2, 2, 0, 3, 0, 1);
    run_layer(2, 3, 2, 2, 2, 1, 1, 0);
    run_zero_cfg(3, 3, 2, 0);
    run_zero_cfg(0, 2, 1, 1);
    for (int i = 0; i < 6; i++)
      run_layer($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 3),
                $urandom_range(1, 3), 2, $urandom_range(1, 4), 1'($urandom_range(0, 1)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
